// File: rtl/mix_pkg.sv
// Shared constants and types for the MIX jump sequencer: opcodes, field codes,
// comparison-indicator encodings and the address space size.
package mix_pkg;

    localparam int AW        = 12;
    localparam int MEM_WORDS = 4000;

    localparam logic [5:0] OP_JMP    = 6'd39;
    localparam logic [5:0] OP_J_BASE = 6'd40;
    localparam logic [5:0] OP_J_LAST = 6'd47;

    // C=39 field codes
    localparam logic [3:0] F_JMP  = 4'd0;
    localparam logic [3:0] F_JSJ  = 4'd1;
    localparam logic [3:0] F_JOV  = 4'd2;
    localparam logic [3:0] F_JNOV = 4'd3;
    localparam logic [3:0] F_JL   = 4'd4;
    localparam logic [3:0] F_JE   = 4'd5;
    localparam logic [3:0] F_JG   = 4'd6;
    localparam logic [3:0] F_JGE  = 4'd7;
    localparam logic [3:0] F_JNE  = 4'd8;
    localparam logic [3:0] F_JLE  = 4'd9;

    // C=40..47 field codes
    localparam logic [3:0] F_RN  = 4'd0;
    localparam logic [3:0] F_RZ  = 4'd1;
    localparam logic [3:0] F_RP  = 4'd2;
    localparam logic [3:0] F_RNN = 4'd3;
    localparam logic [3:0] F_RNZ = 4'd4;
    localparam logic [3:0] F_RNP = 4'd5;

    localparam logic [1:0] CMP_E = 2'b00;
    localparam logic [1:0] CMP_L = 2'b01;
    localparam logic [1:0] CMP_G = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_EVAL   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    function automatic logic is_reg_jump(input logic [5:0] op);
        return (op >= OP_J_BASE) && (op <= OP_J_LAST);
    endfunction

endpackage

// File: rtl/mix_jump_unit_if.sv
// Request/commit bundle between the decoder, register file and the jump sequencer.
interface mix_jump_unit_if
    import mix_pkg::*;
#(
    parameter int W = AW
) ();
    logic         start;
    logic [5:0]   opcode;
    logic [3:0]   field;
    logic [W-1:0] addr;
    logic [W-1:0] pc;
    logic [1:0]   cmp;
    logic         ov;
    logic [2:0]   reg_sel;
    logic [30:0]  reg_data;
    logic         busy;
    logic         pc_we;
    logic [W-1:0] pc_next;
    logic         rj_we;
    logic [W-1:0] rj_data;
    logic         ov_clr;
    logic         done;
    logic         taken;
    logic         illegal;

    modport master (
        output start, opcode, field, addr, pc, cmp, ov, reg_data,
        input  reg_sel, busy, pc_we, pc_next, rj_we, rj_data, ov_clr, done, taken, illegal
    );

    modport slave (
        input  start, opcode, field, addr, pc, cmp, ov, reg_data,
        output reg_sel, busy, pc_we, pc_next, rj_we, rj_data, ov_clr, done, taken, illegal
    );
endinterface

// File: rtl/mix_jmp_cond.sv
// Combinational jump-condition evaluator for C=39 and C=40..47.
// Negative zero counts as zero: it is neither negative nor positive.
module mix_jmp_cond
    import mix_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [3:0]  i_field,
    input  logic [30:0] i_reg_data,
    input  logic        i_ov,
    input  logic [1:0]  i_cmp,
    output logic        o_taken,
    output logic        o_field_ok
);
    logic w_zero;
    logic w_neg;
    logic w_pos;

    assign w_zero = (i_reg_data[29:0] == 30'd0);
    assign w_neg  = i_reg_data[30] & ~w_zero;
    assign w_pos  = ~i_reg_data[30] & ~w_zero;

    always_comb begin
        o_taken    = 1'b0;
        o_field_ok = 1'b0;
        if (i_opcode == OP_JMP) begin
            o_field_ok = (i_field <= F_JLE);
            case (i_field)
                F_JMP, F_JSJ: o_taken = 1'b1;
                F_JOV:        o_taken = i_ov;
                F_JNOV:       o_taken = ~i_ov;
                F_JL:         o_taken = (i_cmp == CMP_L);
                F_JE:         o_taken = (i_cmp == CMP_E);
                F_JG:         o_taken = (i_cmp == CMP_G);
                F_JGE:        o_taken = (i_cmp == CMP_E) || (i_cmp == CMP_G);
                F_JNE:        o_taken = (i_cmp == CMP_L) || (i_cmp == CMP_G);
                F_JLE:        o_taken = (i_cmp == CMP_E) || (i_cmp == CMP_L);
                default:      o_taken = 1'b0;
            endcase
        end else if (is_reg_jump(i_opcode)) begin
            o_field_ok = (i_field <= F_RNP);
            case (i_field)
                F_RN:    o_taken = w_neg;
                F_RZ:    o_taken = w_zero;
                F_RP:    o_taken = w_pos;
                F_RNN:   o_taken = ~w_neg;
                F_RNZ:   o_taken = ~w_zero;
                F_RNP:   o_taken = ~w_pos;
                default: o_taken = 1'b0;
            endcase
        end
    end
endmodule

// File: rtl/mix_jump_unit.sv
// MIX jump sequencer: latches a jump request, optionally reads the tested register,
// evaluates the condition and commits PC / rJ / overflow-clear in one strobe cycle.
module mix_jump_unit #(
    parameter int MEM_WORDS = mix_pkg::MEM_WORDS,
    parameter int AW        = mix_pkg::AW
) (
    input logic            clk,
    input logic            rst,
    mix_jump_unit_if.slave bus
);
    import mix_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_WORDS - 1);

    state_t r_state;
    state_t w_state_next;
    logic   w_latch;
    logic   w_eval;

    logic [5:0]    r_opcode;
    logic [3:0]    r_field;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_pc;
    logic [1:0]    r_cmp;
    logic          r_ov;
    logic [30:0]   r_reg_data;
    logic [2:0]    r_reg_sel;

    logic          r_pc_we;
    logic          r_rj_we;
    logic          r_ov_clr;
    logic          r_done;
    logic          r_taken;
    logic          r_illegal;
    logic [AW-1:0] r_pc_next;
    logic [AW-1:0] r_rj_data;

    logic          w_cond_taken;
    logic          w_field_ok;
    logic          w_legal;
    logic          w_taken;
    logic          w_is_jsj;
    logic          w_is_ovop;
    logic [AW-1:0] w_pc_inc;

    mix_jmp_cond u_cond (
        .i_opcode   (r_opcode),
        .i_field    (r_field),
        .i_reg_data (r_reg_data),
        .i_ov       (r_ov),
        .i_cmp      (r_cmp),
        .o_taken    (w_cond_taken),
        .o_field_ok (w_field_ok)
    );

    // A taken jump to an address outside memory is rejected as a whole.
    assign w_legal   = w_field_ok & ~(w_cond_taken & (r_addr > LAST_ADDR));
    assign w_taken   = w_legal & w_cond_taken;
    assign w_is_jsj  = (r_opcode == OP_JMP) && (r_field == F_JSJ);
    assign w_is_ovop = (r_opcode == OP_JMP) && ((r_field == F_JOV) || (r_field == F_JNOV));
    assign w_pc_inc  = (r_pc == LAST_ADDR) ? '0 : r_pc + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_eval       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_latch = 1'b1;
                    // Only a well-formed register jump needs the register-file read.
                    w_state_next = (is_reg_jump(bus.opcode) && (bus.field <= F_RNP))
                                   ? ST_READ : ST_EVAL;
                end
            end
            ST_READ:   w_state_next = ST_EVAL;
            ST_EVAL: begin
                w_eval       = 1'b1;
                w_state_next = ST_COMMIT;
            end
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode   <= '0;
            r_field    <= '0;
            r_addr     <= '0;
            r_pc       <= '0;
            r_cmp      <= '0;
            r_ov       <= 1'b0;
            r_reg_data <= '0;
            r_reg_sel  <= '0;
            r_pc_we    <= 1'b0;
            r_rj_we    <= 1'b0;
            r_ov_clr   <= 1'b0;
            r_done     <= 1'b0;
            r_taken    <= 1'b0;
            r_illegal  <= 1'b0;
            r_pc_next  <= '0;
            r_rj_data  <= '0;
        end else begin
            r_pc_we  <= 1'b0;
            r_rj_we  <= 1'b0;
            r_ov_clr <= 1'b0;
            r_done   <= 1'b0;
            if (w_latch) begin
                r_opcode  <= bus.opcode;
                r_field   <= bus.field;
                r_addr    <= bus.addr;
                r_pc      <= bus.pc;
                r_cmp     <= bus.cmp;
                r_ov      <= bus.ov;
                r_reg_sel <= is_reg_jump(bus.opcode) ? 3'(bus.opcode - OP_J_BASE) : 3'd0;
            end
            if (r_state == ST_READ) r_reg_data <= bus.reg_data;
            if (w_eval) begin
                r_done    <= 1'b1;
                r_pc_we   <= w_legal;
                r_rj_we   <= w_taken & ~w_is_jsj;
                r_ov_clr  <= w_legal & w_is_ovop & r_ov;
                r_taken   <= w_taken;
                r_illegal <= ~w_legal;
                r_pc_next <= w_taken ? r_addr : w_pc_inc;
                r_rj_data <= w_pc_inc;
            end
        end
    end

    assign bus.reg_sel = r_reg_sel;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.pc_we   = r_pc_we;
    assign bus.pc_next = r_pc_next;
    assign bus.rj_we   = r_rj_we;
    assign bus.rj_data = r_rj_data;
    assign bus.ov_clr  = r_ov_clr;
    assign bus.done    = r_done;
    assign bus.taken   = r_taken;
    assign bus.illegal = r_illegal;

endmodule
